// File: rtl/piso_serializer_if.sv
// Load and serial-link signal bundle for piso_serializer.
// The serializer takes the slave side; the producer/consumer side takes master.
interface piso_serializer_if #(
    parameter int DATA_LENGTH = 12
);
    logic                   load_valid;
    logic                   load_ready;
    logic [DATA_LENGTH-1:0] data_in_p;
    logic                   ser_out;
    logic                   ser_valid;
    logic                   ser_ready;
    logic                   ser_last;
    logic                   busy;

    modport slave (
        input  load_valid,
        input  data_in_p,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );

    modport master (
        output load_valid,
        output data_in_p,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: loads a word on a valid/ready handshake and
// emits it one bit per accepted beat, with a frame-last marker and backpressure.
module piso_serializer #(
    parameter int DATA_LENGTH = 12,
    parameter int MSB_FIRST   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    piso_serializer_if.slave    bus
);
    localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [DATA_LENGTH-1:0] shreg_r;
    logic [DATA_LENGTH-1:0] shreg_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_s;

    logic                   is_shift_s;
    logic                   last_s;
    logic                   head_s;
    logic [DATA_LENGTH-1:0] shifted_s;
    logic                   load_ready_s;
    logic                   load_hs_s;
    logic                   beat_s;

    // The output end of the shift register depends on bit order; the vacated bit is zero-filled.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign head_s    = shreg_r[DATA_LENGTH-1];
            assign shifted_s = {shreg_r[DATA_LENGTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_s    = shreg_r[0];
            assign shifted_s = {1'b0, shreg_r[DATA_LENGTH-1:1]};
        end
    endgenerate

    assign is_shift_s   = (state_r == ST_SHIFT);
    assign last_s       = is_shift_s & (count_r == LAST_CNT);
    // A word may be accepted in the same cycle the previous one retires, so frames run back-to-back.
    assign load_ready_s = ~is_shift_s | (last_s & bus.ser_ready);
    assign load_hs_s    = bus.load_valid & load_ready_s;
    assign beat_s       = is_shift_s & bus.ser_ready;

    assign bus.load_ready = load_ready_s;
    assign bus.ser_valid  = is_shift_s;
    assign bus.ser_out    = is_shift_s & head_s;
    assign bus.ser_last   = last_s;
    assign bus.busy       = is_shift_s;

    // Next-state, shift and count decode.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (load_hs_s) begin
                    state_s = ST_SHIFT;
                    shreg_s = bus.data_in_p;
                    count_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (beat_s) begin
                    if (!last_s) begin
                        shreg_s = shifted_s;
                        count_s = count_r + CNT_W'(1);
                    end else if (load_hs_s) begin
                        shreg_s = bus.data_in_p;
                        count_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                        shreg_s = '0;
                        count_s = '0;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                shreg_s = '0;
                count_s = '0;
            end
        endcase
    end

    // State, shift register and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            count_r <= count_s;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: MSB-first and LSB-first
// instances, stalls, back-to-back frames, mid-word load attempts and reset.
module tb_piso_serializer;
    logic clk;
    logic reset_n;

    int tests_run;
    int tests_failed;

    piso_serializer_if #(.DATA_LENGTH(12)) a_if ();
    piso_serializer_if #(.DATA_LENGTH(12)) b_if ();

    piso_serializer #(.DATA_LENGTH(12), .MSB_FIRST(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if.slave)
    );

    piso_serializer #(.DATA_LENGTH(12), .MSB_FIRST(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit use_b, input logic lv, input logic [11:0] data, input logic rdy);
        if (use_b) begin
            b_if.load_valid = lv;
            b_if.data_in_p  = data;
            b_if.ser_ready  = rdy;
        end else begin
            a_if.load_valid = lv;
            a_if.data_in_p  = data;
            a_if.ser_ready  = rdy;
        end
    endtask

    task automatic sample(input bit use_b, output logic ov, output logic oo,
                          output logic ol, output logic olr, output logic ob);
        if (use_b) begin
            ov = b_if.ser_valid; oo = b_if.ser_out; ol = b_if.ser_last;
            olr = b_if.load_ready; ob = b_if.busy;
        end else begin
            ov = a_if.ser_valid; oo = a_if.ser_out; ol = a_if.ser_last;
            olr = a_if.load_ready; ob = a_if.busy;
        end
    endtask

    // Present a word for one cycle; ends on the negedge after the handshake edge.
    task automatic load_word(input string tag, input bit use_b, input logic [11:0] word);
        logic ov, oo, ol, olr, ob;
        @(negedge clk);
        drive(use_b, 1'b1, word, 1'b1);
        #1;
        sample(use_b, ov, oo, ol, olr, ob);
        check({tag, "_ld_ready"}, 32'(olr), 32'd1);
        check({tag, "_ld_busy"}, 32'(ob), 32'd0);
        @(negedge clk);
    endtask

    // Check beats against seq (first bit in seq[11]); ends on the negedge after the last beat.
    task automatic stream(input string tag, input bit use_b, input logic [11:0] seq,
                          input bit stall, input int lv_until, input logic [11:0] next_word,
                          input int stop_at);
        logic ov, oo, ol, olr, ob;
        logic rdy;
        int   beats;
        int   cyc;
        beats = 0;
        cyc   = 0;
        while (beats < stop_at && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            drive(use_b, (beats < lv_until), next_word, rdy);
            #1;
            sample(use_b, ov, oo, ol, olr, ob);
            check({tag, "_valid"}, 32'(ov), 32'd1);
            check({tag, "_busy"}, 32'(ob), 32'd1);
            check({tag, "_out"}, 32'(oo), 32'(seq[11 - beats]));
            check({tag, "_last"}, 32'(ol), 32'(beats == 11));
            check({tag, "_ld_ready"}, 32'(olr), 32'((beats == 11) && rdy));
            if (rdy) beats++;
            cyc++;
            @(negedge clk);
        end
        check({tag, "_beats"}, 32'(beats), 32'(stop_at));
    endtask

    task automatic check_idle(input string tag, input bit use_b);
        logic ov, oo, ol, olr, ob;
        drive(use_b, 1'b0, 12'h000, 1'b1);
        #1;
        sample(use_b, ov, oo, ol, olr, ob);
        check({tag, "_valid"}, 32'(ov), 32'd0);
        check({tag, "_busy"}, 32'(ob), 32'd0);
        check({tag, "_out"}, 32'(oo), 32'd0);
        check({tag, "_last"}, 32'(ol), 32'd0);
        check({tag, "_ld_ready"}, 32'(olr), 32'd1);
    endtask

    initial begin
        logic ov, oo, ol, olr, ob;
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        check_idle("rst_a", 1'b0);
        check_idle("rst_b", 1'b1);
        reset_n = 1'b1;

        // Plain MSB-first word, 0xA5C -> 1,0,1,0,0,1,0,1,1,1,0,0
        load_word("a5c", 1'b0, 12'hA5C);
        stream("a5c", 1'b0, 12'b101001011100, 1'b0, 0, 12'h3C3, 12);
        check_idle("a5c_end", 1'b0);

        // Same word under 1,0,0 backpressure
        load_word("stall", 1'b0, 12'hA5C);
        stream("stall", 1'b0, 12'b101001011100, 1'b1, 0, 12'h000, 12);
        check_idle("stall_end", 1'b0);

        // Back-to-back 0xFFF then 0x001 with load_valid held through the first frame
        load_word("b2b1", 1'b0, 12'hFFF);
        stream("b2b1", 1'b0, 12'b111111111111, 1'b0, 12, 12'h001, 12);
        stream("b2b2", 1'b0, 12'b000000000001, 1'b0, 0, 12'h000, 12);
        check_idle("b2b_end", 1'b0);

        // LSB-first instance, 0x0F3 -> 1,1,0,0,1,1,1,1,0,0,0,0
        load_word("lsb", 1'b1, 12'h0F3);
        stream("lsb", 1'b1, 12'b110011110000, 1'b0, 0, 12'hFFF, 12);
        check_idle("lsb_end", 1'b1);

        // Load attempts mid-word are refused until the final beat
        load_word("midld", 1'b0, 12'hA5C);
        stream("midld", 1'b0, 12'b101001011100, 1'b0, 11, 12'h000, 12);
        check_idle("midld_end", 1'b0);

        // Reset after the 5th beat abandons the word at once
        load_word("rst5", 1'b0, 12'hA5C);
        stream("rst5", 1'b0, 12'b101001011100, 1'b0, 0, 12'h000, 5);
        #1;
        sample(1'b0, ov, oo, ol, olr, ob);
        check("rst5_pre_busy", 32'(ob), 32'd1);
        check("rst5_pre_out", 32'(oo), 32'd1);
        reset_n = 1'b0;
        #1;
        sample(1'b0, ov, oo, ol, olr, ob);
        check("rst5_async_valid", 32'(ov), 32'd0);
        check("rst5_async_busy", 32'(ob), 32'd0);
        check("rst5_async_out", 32'(oo), 32'd0);
        check("rst5_async_last", 32'(ol), 32'd0);
        check("rst5_async_ld_ready", 32'(olr), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        check_idle("rst5_idle", 1'b0);
        load_word("x800", 1'b0, 12'h800);
        stream("x800", 1'b0, 12'b100000000000, 1'b0, 0, 12'h000, 12);
        check_idle("x800_end", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out shifter and the transmit counterpart of the ALU parallel-load register.
- Accepts a DATA_LENGTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per accepted serial beat, with a frame-last marker and downstream backpressure.
- Sits between the ALU result registers and the bit-serial output link.

Parameters:
- DATA_LENGTH, 12: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 shifts bit DATA_LENGTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load_valid  input  1  data_in_p holds a word to serialize.
- load_ready  output  1  the block accepts a word this cycle.
- data_in_p  input  DATA_LENGTH  parallel word; sampled only on a load handshake.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  the downstream consumer accepts the current bit.
- ser_last  output  1  the current bit is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset: state goes to IDLE. Shift register and bit counter clear to 0. ser_valid=0, ser_last=0, ser_out=0, busy=0, load_ready=1.
- Handshakes: a load handshake is load_valid & load_ready at a rising edge. A beat is ser_valid & ser_ready at a rising edge.
- Bit counter: width clog2(DATA_LENGTH), counts 0..DATA_LENGTH-1 and never wraps past DATA_LENGTH-1.
- Output registers: the internal shift register, counter and state are registered. ser_out, ser_valid, ser_last and busy are pure decodes of those registers.
- State IDLE:
  - load_ready=1, ser_valid=0, ser_out=0.
  - On a load handshake: capture data_in_p, set count=0, go to SHIFT.
- State SHIFT:
  - ser_valid=1.
  - ser_out = shreg[DATA_LENGTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - ser_last = (count == DATA_LENGTH-1).
  - With ser_ready=0: all state holds; ser_out and ser_last stay stable.
  - On a beat with ser_last=0: shift toward the output end, zero-filling the vacated bit, and increment count.
  - On a beat with ser_last=1 and no load handshake: go to IDLE.
- load_ready = IDLE | (SHIFT & ser_last & ser_ready). It is combinational from ser_ready; this is the only combinational input-to-output path.
- Back-to-back words: final beat plus a simultaneous load handshake reloads shreg, sets count=0 and stays in SHIFT. The next word's first bit appears the next cycle with no idle gap.
- Latency: the first bit of a word is on ser_out one cycle after its load handshake. A word takes exactly DATA_LENGTH beats.
- Ignored input: data_in_p and load_valid outside a load handshake have no effect. Changing data_in_p mid-word does not corrupt the word in flight.
- Reset mid-word: the partial word is abandoned immediately and asynchronously. No ser_last is produced for it. After reset_n rises, the block is in IDLE.
- ser_ready in IDLE: ignored.

Test Plan:
- DATA_LENGTH=12, MSB_FIRST=1, load 0xA5C, ser_ready=1 held -> ser_out = 1,0,1,0,0,1,0,1,1,1,0,0 on 12 consecutive cycles starting one cycle after the handshake. ser_last high only on the 12th bit, busy low on the following cycle.
- Same word, ser_ready toggled 1,0,0,1,... -> ser_out and ser_last frozen on every ser_ready=0 cycle. The bit sequence is identical to the previous test, and exactly 12 beats occur.
- Back-to-back: 0xFFF then 0x001 with load_valid held high -> 24 contiguous valid beats with no gap. The sequence is twelve 1s then 0,0,0,0,0,0,0,0,0,0,0,1. ser_last is asserted on beats 12 and 24, and load_ready is pulsed on beat 12.
- MSB_FIRST=0, load 0x0F3 -> ser_out = 1,1,0,0,1,1,1,1,0,0,0,0, with ser_last on the 12th bit.
- reset_n pulsed low after the 5th beat of 0xA5C -> ser_valid, busy and ser_out drop to 0 immediately and load_ready=1. A fresh load of 0x800 then yields 1 followed by eleven 0s.
- load_valid asserted while busy with ser_last=0 -> load_ready=0, no capture, and the in-flight word completes unchanged.
